// File: rtl/ro_enc_ctrl.sv
// Service controller for the rotary-encoder counter: settle, capture, clear,
// then convert captures to accelerated signed steps behind a valid/ack handshake.
module ro_enc_ctrl #(
    parameter int SETTLE_CLKS = 50000,
    parameter int ACC_W       = 12,
    parameter int ACCEL_TH    = 4,
    parameter int ACCEL_SHIFT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_ro_enc_irq,
    input  logic             i_ro_enc_dir,
    input  logic [4:0]       i_ro_enc_data,
    output logic             o_sw_intr_clear,
    output logic             o_step_valid,
    output logic [ACC_W-1:0] o_step_val,
    input  logic             i_step_ack,
    output logic             o_busy
);

    localparam int TMR_W = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;
    // Wide enough for acc plus the largest shifted 5-bit count without overflow
    localparam int SUM_W = ACC_W + ACCEL_SHIFT + 8;

    localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(SETTLE_CLKS - 1);
    localparam logic [TMR_W-1:0]        TMR_ONE  = TMR_W'(1);
    localparam logic [31:0]             TH_U     = 32'(ACCEL_TH);
    localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN  = -SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    function automatic logic signed [SUM_W-1:0] step_delta(
        input logic [4:0] cnt,
        input logic       dir
    );
        logic signed [SUM_W-1:0] mag;
        mag = {{(SUM_W-5){1'b0}}, cnt};
        if ({27'd0, cnt} >= TH_U) begin
            mag = mag <<< ACCEL_SHIFT;
        end else begin
            mag = mag;
        end
        step_delta = dir ? -mag : mag;
    endfunction

    // Symmetric clamp: the most negative code is never produced
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0]        a,
        input logic signed [SUM_W-1:0] d
    );
        logic signed [SUM_W-1:0] s;
        s = $signed({{(SUM_W-ACC_W){a[ACC_W-1]}}, a}) + d;
        if (s > SAT_MAX) begin
            sat_add = SAT_MAX[ACC_W-1:0];
        end else if (s < SAT_MIN) begin
            sat_add = SAT_MIN[ACC_W-1:0];
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    state_t             state_r, state_n;
    logic [TMR_W-1:0]   timer_r, timer_n;
    logic [4:0]         last_data_r, last_data_n;
    logic [4:0]         cap_cnt_r, cap_cnt_n;
    logic               cap_dir_r, cap_dir_n;
    logic               discard_r, discard_n;
    logic [ACC_W-1:0]   acc_r, acc_n;
    logic               step_valid_r, step_valid_n;
    logic [ACC_W-1:0]   step_val_r, step_val_n;
    logic               clear_r;
    logic               busy_r;
    logic               conv_s;
    logic               load_s;
    logic [ACC_W-1:0]   acc_base_s;

    // Next-state and capture logic for the service FSM
    always_comb begin
        state_n     = state_r;
        timer_n     = timer_r;
        last_data_n = last_data_r;
        cap_cnt_n   = cap_cnt_r;
        cap_dir_n   = cap_dir_r;
        discard_n   = discard_r;
        case (state_r)
            ST_IDLE: begin
                if (i_ro_enc_irq && i_en) begin
                    state_n     = ST_SETTLE;
                    timer_n     = {TMR_W{1'b0}};
                    last_data_n = i_ro_enc_data;
                    discard_n   = 1'b0;
                end else if (i_ro_enc_irq) begin
                    state_n   = ST_CLEAR;
                    discard_n = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!i_en) begin
                    state_n   = ST_CLEAR;
                    discard_n = 1'b1;
                end else if (i_ro_enc_data != last_data_r) begin
                    timer_n     = {TMR_W{1'b0}};
                    last_data_n = i_ro_enc_data;
                end else if (timer_r == TMR_LAST) begin
                    cap_cnt_n = i_ro_enc_data;
                    cap_dir_n = i_ro_enc_dir;
                    discard_n = 1'b0;
                    state_n   = ST_CLEAR;
                end else begin
                    timer_n = timer_r + TMR_ONE;
                end
            end
            ST_CLEAR: begin
                state_n = ST_GAP;
            end
            ST_GAP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Step accumulation and output handshake; a load empties acc before any new capture adds in
    always_comb begin
        conv_s       = (state_r == ST_CLEAR) && !discard_r;
        load_s       = !step_valid_r && (acc_r != {ACC_W{1'b0}});
        acc_base_s   = load_s ? {ACC_W{1'b0}} : acc_r;
        step_val_n   = step_val_r;
        step_valid_n = step_valid_r;
        if (conv_s) begin
            acc_n = sat_add(acc_base_s, step_delta(cap_cnt_r, cap_dir_r));
        end else begin
            acc_n = acc_base_s;
        end
        if (load_s) begin
            step_valid_n = 1'b1;
            step_val_n   = acc_r;
        end else if (step_valid_r && i_step_ack) begin
            step_valid_n = 1'b0;
        end else begin
            step_valid_n = step_valid_r;
        end
    end

    // State, datapath and registered output flops
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TMR_W{1'b0}};
            last_data_r  <= 5'd0;
            cap_cnt_r    <= 5'd0;
            cap_dir_r    <= 1'b0;
            discard_r    <= 1'b0;
            acc_r        <= {ACC_W{1'b0}};
            step_valid_r <= 1'b0;
            step_val_r   <= {ACC_W{1'b0}};
            clear_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            timer_r      <= timer_n;
            last_data_r  <= last_data_n;
            cap_cnt_r    <= cap_cnt_n;
            cap_dir_r    <= cap_dir_n;
            discard_r    <= discard_n;
            acc_r        <= acc_n;
            step_valid_r <= step_valid_n;
            step_val_r   <= step_val_n;
            clear_r      <= (state_n == ST_CLEAR);
            busy_r       <= (state_n != ST_IDLE);
        end
    end

    assign o_sw_intr_clear = clear_r;
    assign o_step_valid    = step_valid_r;
    assign o_step_val      = step_val_r;
    assign o_busy          = busy_r;

endmodule

// File: tb/tb_ro_enc_ctrl.sv
// Bench for ro_enc_ctrl: directed scenarios then randomized episodes, two
// accumulator widths side by side, checked against an arithmetic model.
module tb_ro_enc_ctrl;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        irq;
    logic        dir;
    logic [4:0]  data;
    logic        ack;
    logic        clr_a, vld_a, busy_a;
    logic [11:0] val_a;
    logic        clr_b, vld_b, busy_b;
    logic [5:0]  val_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int acc_m[2];
    int val_m[2];
    bit vld_m[2];
    int maxv[2] = '{2047, 31};

    int q_d[$];
    bit q_r[$];
    int q_g[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ro_enc_ctrl #(.SETTLE_CLKS(S), .ACC_W(12), .ACCEL_TH(4), .ACCEL_SHIFT(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ro_enc_irq(irq), .i_ro_enc_dir(dir),
        .i_ro_enc_data(data), .o_sw_intr_clear(clr_a), .o_step_valid(vld_a),
        .o_step_val(val_a), .i_step_ack(ack), .o_busy(busy_a)
    );

    ro_enc_ctrl #(.SETTLE_CLKS(S), .ACC_W(6), .ACCEL_TH(4), .ACCEL_SHIFT(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ro_enc_irq(irq), .i_ro_enc_dir(dir),
        .i_ro_enc_data(data), .o_sw_intr_clear(clr_b), .o_step_valid(vld_b),
        .o_step_val(val_b), .i_step_ack(ack), .o_busy(busy_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input int c);
        return (c >= 4) ? c * 4 : c;
    endfunction

    function automatic int sat(input int v, input int m);
        if (v > m) return m;
        if (v < -m) return -m;
        return v;
    endfunction

    task automatic model_load();
        for (int i = 0; i < 2; i++) begin
            if (!vld_m[i] && acc_m[i] != 0) begin
                val_m[i] = acc_m[i];
                acc_m[i] = 0;
                vld_m[i] = 1'b1;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_vld_a"}, int'(vld_a), int'(vld_m[0]));
        chk({tag, "_val_a"}, int'($signed(val_a)), val_m[0]);
        chk({tag, "_vld_b"}, int'(vld_b), int'(vld_m[1]));
        chk({tag, "_val_b"}, int'($signed(val_b)), val_m[1]);
    endtask

    task automatic setq();
        q_d.delete();
        q_r.delete();
        q_g.delete();
    endtask

    task automatic push(input int d, input bit r, input int g);
        q_d.push_back(d);
        q_r.push_back(r);
        q_g.push_back(g);
    endtask

    // drop_k > 0: enable falls drop_k cycles after the last count change
    task automatic run_episode(input bit en_v, input int drop_k, input string tag);
        int chg, exp_clr, na, nb, first, m;
        na = 0;
        nb = 0;
        first = -1;
        chg = 0;
        repeat (2) @(negedge clk);
        en = en_v;
        for (int i = 0; i < q_d.size(); i++) begin
            if (i > 0) repeat (q_g[i-1] - 1) @(negedge clk);
            @(negedge clk);
            data = 5'(q_d[i]);
            dir  = q_r[i];
            irq  = 1'b1;
            chg  = cyc;
        end
        if (!en_v) exp_clr = chg + 1;
        else if (drop_k > 0) exp_clr = chg + drop_k + 1;
        else exp_clr = chg + S + 1;
        for (int k = 0; k < S + 8; k++) begin
            @(negedge clk);
            if (cyc == chg + 1) begin
                chk({tag, "_busy_a"}, int'(busy_a), 1);
                chk({tag, "_busy_b"}, int'(busy_b), 1);
            end
            if (clr_a) begin
                na++;
                if (first < 0) first = cyc;
                irq  = 1'b0;
                data = 5'd0;
            end
            if (clr_b) nb++;
            if (drop_k > 0 && cyc == chg + drop_k) en = 1'b0;
        end
        chk({tag, "_nclr_a"}, na, 1);
        chk({tag, "_nclr_b"}, nb, 1);
        chk({tag, "_clr_time"}, first, exp_clr);
        en = 1'b1;
        if (en_v && drop_k == 0) begin
            m = mag_of(q_d[q_d.size()-1]);
            if (q_r[q_r.size()-1]) m = -m;
            for (int i = 0; i < 2; i++) acc_m[i] = sat(acc_m[i] + m, maxv[i]);
        end
        model_load();
        check_outs(tag);
        chk({tag, "_idle_a"}, int'(busy_a), 0);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        for (int i = 0; i < 2; i++) vld_m[i] = 1'b0;
        chk({tag, "_ackdrop_a"}, int'(vld_a), 0);
        chk({tag, "_ackdrop_b"}, int'(vld_b), 0);
        @(negedge clk);
        model_load();
        check_outs({tag, "_post"});
    endtask

    initial begin
        int mode, n, prev, d;
        rst = 1'b0; en = 1'b1; irq = 1'b0; dir = 1'b0; data = 5'd0; ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            acc_m[i] = 0; val_m[i] = 0; vld_m[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_clr", int'(clr_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        check_outs("rst");
        rst = 1'b1;

        setq(); push(1, 1'b0, 1);
        run_episode(1'b1, 0, "single");
        do_ack("single");

        setq(); push(1, 1'b1, 10); push(2, 1'b1, 10); push(3, 1'b1, 10);
        run_episode(1'b1, 0, "restart");
        do_ack("restart");

        setq(); push(5, 1'b0, 1);
        run_episode(1'b1, 0, "accel5");
        do_ack("accel5");
        setq(); push(3, 1'b0, 1);
        run_episode(1'b1, 0, "accel3");
        do_ack("accel3");

        setq(); push(2, 1'b0, 1);
        run_episode(1'b1, 0, "bp_first");
        setq(); push(5, 1'b1, 1);
        run_episode(1'b1, 0, "bp_second");
        do_ack("bp");
        do_ack("bp2");

        for (int j = 0; j < 3; j++) begin
            setq(); push(24, 1'b0, 1);
            run_episode(1'b1, 0, "sat");
        end
        chk("sat_val_b", int'($signed(val_b)), 31);

        setq(); push(7, 1'b0, 1);
        run_episode(1'b0, 0, "disable");

        @(negedge clk);
        en = 1'b1; irq = 1'b1; data = 5'd7; dir = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", int'(busy_a), 1);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            acc_m[i] = 0; val_m[i] = 0; vld_m[i] = 1'b0;
        end
        chk("midrst_clr_a", int'(clr_a), 0);
        chk("midrst_busy_a", int'(busy_a), 0);
        chk("midrst_busy_b", int'(busy_b), 0);
        check_outs("midrst");
        irq = 1'b0; data = 5'd0;
        @(negedge clk);
        rst = 1'b1;

        for (int e = 0; e < 40; e++) begin
            setq();
            mode = $urandom_range(0, 9);
            n = (mode == 0) ? 1 : $urandom_range(1, 4);
            prev = -1;
            for (int k = 0; k < n; k++) begin
                d = $urandom_range(0, 31);
                while (d == prev) d = $urandom_range(0, 31);
                prev = d;
                push(d, 1'($urandom_range(0, 1)), $urandom_range(1, S - 4));
            end
            if (mode == 0) run_episode(1'b0, 0, "rnd_dis");
            else if (mode == 1) run_episode(1'b1, $urandom_range(1, S - 2), "rnd_drop");
            else run_episode(1'b1, 0, "rnd");
            if ($urandom_range(0, 1) == 1) do_ack("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
